// File: rtl/multicycle_control_unit_pkg.sv
// Shared types and encodings for the RV32I multicycle control unit.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXEC_R    = 4'd6,
    ST_EXEC_I    = 4'd7,
    ST_EXEC_U    = 4'd8,
    ST_ALU_WB    = 4'd9,
    ST_JALR_ADDR = 4'd10,
    ST_JAL       = 4'd11,
    ST_BRANCH    = 4'd12,
    ST_HALT      = 4'd13
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_ctrl_t;

  // What the current state wants from the ALU; FUNCT defers to funct3/funct7_5.
  typedef enum logic [1:0] {
    ALU_CLS_ADD   = 2'd0,
    ALU_CLS_SUB   = 2'd1,
    ALU_CLS_FUNCT = 2'd2
  } alu_class_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;
  localparam logic [1:0] SRC_A_ZERO   = 2'b11;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALU_OUT    = 2'b00;
  localparam logic [1:0] RES_MEM_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU_RESULT = 2'b10;

  function automatic logic [2:0] imm_src_for(input logic [6:0] op);
    case (op)
      OP_STORE:         return IMM_S;
      OP_BRANCH:        return IMM_B;
      OP_LUI, OP_AUIPC: return IMM_U;
      OP_JAL:           return IMM_J;
      default:          return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// Maps the requested ALU class plus instruction fields to an ALU operation code.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_class,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic [6:0] opcode,
  output logic [3:0] alu_ctrl
);

  logic is_r;

  // Only register-register ops use funct7_5 to pick SUB; addi must ignore it.
  assign is_r = (opcode == OP_R);

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_class)
      ALU_CLS_SUB: alu_ctrl = ALU_SUB;
      ALU_CLS_FUNCT: begin
        case (funct3)
          3'b000:  alu_ctrl = (is_r && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl = ALU_SLL;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b011:  alu_ctrl = ALU_SLTU;
          3'b100:  alu_ctrl = ALU_XOR;
          3'b101:  alu_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl = ALU_OR;
          default: alu_ctrl = ALU_AND;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore-style sequencer for the shared-ALU, unified-memory RV32I multicycle datapath.
//
// state      | meaning
// FETCH      | read instr at PC, PC <= PC+4 on mem_ready
// DECODE     | alu_out <= old_pc+imm, dispatch on opcode
// MEM_ADDR   | alu_out <= rs1+imm
// MEM_READ   | load access at alu_out, wait mem_ready
// MEM_WB     | rd <= load data, retire
// MEM_WRITE  | store access at alu_out, retire on mem_ready
// EXEC_R     | alu_out <= rs1 op rs2
// EXEC_I     | alu_out <= rs1 op imm
// EXEC_U     | alu_out <= imm (lui) or old_pc+imm (auipc)
// ALU_WB     | rd <= alu_out, retire
// JALR_ADDR  | alu_out <= rs1+imm (jump target)
// JAL        | PC <= alu_out, alu_out <= old_pc+4
// BRANCH     | compare, PC <= alu_out if taken, retire
// HALT       | idle until reset
module multicycle_control_unit
  import riscv_ctrl_pkg::*;
#(
  parameter bit RESET_STATE_FETCH = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       alu_zero,
  input  logic       alu_lt,
  input  logic       alu_ltu,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [2:0] imm_src,
  output logic [3:0] alu_ctrl,
  output logic       instr_retired,
  output logic       illegal_instr,
  output logic       halted
);

  localparam state_t RESET_STATE = RESET_STATE_FETCH ? ST_FETCH : ST_HALT;

  state_t     state_q, state_d;
  logic [1:0] alu_class;
  logic       taken;

  always_ff @(posedge clk) begin
    if (reset) state_q <= RESET_STATE;
    else       state_q <= state_d;
  end

  always_comb begin
    case (funct3)
      3'b000:  taken = alu_zero;
      3'b001:  taken = !alu_zero;
      3'b100:  taken = alu_lt;
      3'b101:  taken = !alu_lt;
      3'b110:  taken = alu_ltu;
      3'b111:  taken = !alu_ltu;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_RS2;
    result_src    = RES_ALU_OUT;
    imm_src       = IMM_I;
    alu_class     = ALU_CLS_ADD;
    instr_retired = 1'b0;
    illegal_instr = 1'b0;
    halted        = 1'b0;
    // Reset forces everything quiet so an aborted access never writes.
    if (!reset) begin
      imm_src = imm_src_for(opcode);
      case (state_q)
        ST_FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = SRC_B_FOUR;
          result_src = RES_ALU_RESULT;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = ST_DECODE;
          end
        end
        ST_DECODE: begin
          alu_src_a = SRC_A_OLD_PC;
          alu_src_b = SRC_B_IMM;
          case (opcode)
            OP_LOAD, OP_STORE: state_d = ST_MEM_ADDR;
            OP_R:              state_d = ST_EXEC_R;
            OP_I:              state_d = ST_EXEC_I;
            OP_LUI, OP_AUIPC:  state_d = ST_EXEC_U;
            OP_JAL:            state_d = ST_JAL;
            OP_JALR:           state_d = ST_JALR_ADDR;
            OP_BRANCH:         state_d = ST_BRANCH;
            OP_SYSTEM:         state_d = ST_HALT;
            default: begin
              illegal_instr = 1'b1;
              state_d       = ST_FETCH;
            end
          endcase
        end
        ST_MEM_ADDR: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
          state_d   = (opcode == OP_STORE) ? ST_MEM_WRITE : ST_MEM_READ;
        end
        ST_MEM_READ: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
          if (mem_ready) state_d = ST_MEM_WB;
        end
        ST_MEM_WB: begin
          result_src    = RES_MEM_DATA;
          reg_write     = 1'b1;
          instr_retired = 1'b1;
          state_d       = ST_FETCH;
        end
        ST_MEM_WRITE: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          adr_src   = 1'b1;
          if (mem_ready) begin
            instr_retired = 1'b1;
            state_d       = ST_FETCH;
          end
        end
        ST_EXEC_R: begin
          alu_src_a = SRC_A_RS1;
          alu_class = ALU_CLS_FUNCT;
          state_d   = ST_ALU_WB;
        end
        ST_EXEC_I: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
          alu_class = ALU_CLS_FUNCT;
          state_d   = ST_ALU_WB;
        end
        ST_EXEC_U: begin
          alu_src_a = (opcode == OP_LUI) ? SRC_A_ZERO : SRC_A_OLD_PC;
          alu_src_b = SRC_B_IMM;
          state_d   = ST_ALU_WB;
        end
        ST_ALU_WB: begin
          reg_write     = 1'b1;
          instr_retired = 1'b1;
          state_d       = ST_FETCH;
        end
        ST_JALR_ADDR: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
          state_d   = ST_JAL;
        end
        ST_JAL: begin
          alu_src_a = SRC_A_OLD_PC;
          alu_src_b = SRC_B_FOUR;
          pc_write  = 1'b1;
          state_d   = ST_ALU_WB;
        end
        ST_BRANCH: begin
          alu_src_a     = SRC_A_RS1;
          alu_class     = ALU_CLS_SUB;
          pc_write      = taken;
          instr_retired = 1'b1;
          state_d       = ST_FETCH;
        end
        ST_HALT: halted = 1'b1;
        default: state_d = ST_FETCH;
      endcase
    end
  end

  alu_decoder u_alu_decoder (
    .alu_class (alu_class),
    .funct3    (funct3),
    .funct7_5  (funct7_5),
    .opcode    (opcode),
    .alu_ctrl  (alu_ctrl)
  );

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed per-cycle checks of the multicycle control unit's strobes and selects.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       alu_zero, alu_lt, alu_ltu, mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] imm_src;
  logic [3:0] alu_ctrl;
  logic       instr_retired, illegal_instr, halted;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multicycle_control_unit #(.RESET_STATE_FETCH(1'b1)) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7_5      (funct7_5),
    .alu_zero      (alu_zero),
    .alu_lt        (alu_lt),
    .alu_ltu       (alu_ltu),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .mem_write     (mem_write),
    .adr_src       (adr_src),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .result_src    (result_src),
    .imm_src       (imm_src),
    .alu_ctrl      (alu_ctrl),
    .instr_retired (instr_retired),
    .illegal_instr (illegal_instr),
    .halted        (halted)
  );

  // {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, retired, illegal, halted}
  logic [8:0] strb;
  // {alu_src_a, alu_src_b, result_src, alu_ctrl}
  logic [9:0] sel;
  assign strb = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                 instr_retired, illegal_instr, halted};
  assign sel  = {alu_src_a, alu_src_b, result_src, alu_ctrl};

  // Strobe patterns
  localparam logic [8:0] S_NONE   = 9'b000000000;
  localparam logic [8:0] S_FET_W  = 9'b100000000;
  localparam logic [8:0] S_FET_OK = 9'b100110000;
  localparam logic [8:0] S_WB     = 9'b000001100;
  localparam logic [8:0] S_RD     = 9'b101000000;
  localparam logic [8:0] S_WR_W   = 9'b111000000;
  localparam logic [8:0] S_WR_OK  = 9'b111000100;
  localparam logic [8:0] S_BR_T   = 9'b000010100;
  localparam logic [8:0] S_BR_N   = 9'b000000100;
  localparam logic [8:0] S_JAL    = 9'b000010000;
  localparam logic [8:0] S_ILL    = 9'b000000010;
  localparam logic [8:0] S_HALT   = 9'b000000001;
  // Select patterns
  localparam logic [9:0] V_ZERO   = 10'b00_00_00_0000;
  localparam logic [9:0] V_FETCH  = 10'b00_10_10_0000;
  localparam logic [9:0] V_DEC    = 10'b01_01_00_0000;
  localparam logic [9:0] V_RS1IMM = 10'b10_01_00_0000;
  localparam logic [9:0] V_MEMWB  = 10'b00_00_01_0000;
  localparam logic [9:0] V_R_ADD  = 10'b10_00_00_0000;
  localparam logic [9:0] V_R_SUB  = 10'b10_00_00_0001;
  localparam logic [9:0] V_I_SRA  = 10'b10_01_00_0111;
  localparam logic [9:0] V_LUI    = 10'b11_01_00_0000;
  localparam logic [9:0] V_JAL    = 10'b01_10_00_0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_ir(input logic [31:0] ir);
    opcode   = ir[6:0];
    funct3   = ir[14:12];
    funct7_5 = ir[30];
  endtask

  // One clock: drive mem_ready, check combinational outputs, advance.
  task automatic cyc(input string tag, input logic rdy, input logic [8:0] es, input logic [9:0] ev);
    mem_ready = rdy;
    #1;
    check({tag, ".strb"}, {23'b0, strb}, {23'b0, es});
    check({tag, ".sel"}, {22'b0, sel}, {22'b0, ev});
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0;
    alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0;
    set_ir(32'h000000B7); // lui: imm_src would be U if not held quiet
    repeat (3) @(posedge clk);
    #1;
    mem_ready = 1'b1;
    #1;
    check("rst.strb", {23'b0, strb}, 32'd0);
    check("rst.sel", {22'b0, sel}, 32'd0);
    check("rst.imm", {29'b0, imm_src}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // add x3,x1,x2
    set_ir(32'h002081B3);
    cyc("add.fetch", 1'b1, S_FET_OK, V_FETCH);
    cyc("add.dec", 1'b1, S_NONE, V_DEC);
    cyc("add.exec", 1'b1, S_NONE, V_R_ADD);
    cyc("add.wb", 1'b1, S_WB, V_ZERO);

    // lw x5,8(x1) with two wait cycles in MEM_READ
    set_ir(32'h0080A283);
    cyc("lw.fetch", 1'b1, S_FET_OK, V_FETCH);
    check("lw.imm", {29'b0, imm_src}, 32'd0);
    cyc("lw.dec", 1'b1, S_NONE, V_DEC);
    cyc("lw.addr", 1'b0, S_NONE, V_RS1IMM);
    cyc("lw.rd_w0", 1'b0, S_RD, V_ZERO);
    cyc("lw.rd_w1", 1'b0, S_RD, V_ZERO);
    cyc("lw.rd_ok", 1'b1, S_RD, V_ZERO);
    cyc("lw.wb", 1'b1, S_WB, V_MEMWB);

    // beq taken then not taken
    set_ir(32'h00208463);
    alu_zero = 1'b1;
    cyc("beq1.fetch", 1'b1, S_FET_OK, V_FETCH);
    check("beq.imm", {29'b0, imm_src}, 32'd2);
    cyc("beq1.dec", 1'b1, S_NONE, V_DEC);
    cyc("beq1.br", 1'b1, S_BR_T, V_R_SUB);
    alu_zero = 1'b0;
    cyc("beq0.fetch", 1'b1, S_FET_OK, V_FETCH);
    cyc("beq0.dec", 1'b1, S_NONE, V_DEC);
    cyc("beq0.br", 1'b1, S_BR_N, V_R_SUB);

    // bltu taken on ltu only; funct3=010 never taken even with all flags set
    set_ir(32'h0020E463);
    alu_ltu = 1'b1;
    cyc("bltu.fetch", 1'b1, S_FET_OK, V_FETCH);
    cyc("bltu.dec", 1'b1, S_NONE, V_DEC);
    cyc("bltu.br", 1'b1, S_BR_T, V_R_SUB);
    set_ir(32'h0020A463);
    alu_zero = 1'b1; alu_lt = 1'b1;
    cyc("b010.fetch", 1'b1, S_FET_OK, V_FETCH);
    cyc("b010.dec", 1'b1, S_NONE, V_DEC);
    cyc("b010.br", 1'b1, S_BR_N, V_R_SUB);
    alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0;

    // jalr x1,0(x2)
    set_ir(32'h000100E7);
    cyc("jalr.fetch", 1'b1, S_FET_OK, V_FETCH);
    cyc("jalr.dec", 1'b1, S_NONE, V_DEC);
    cyc("jalr.addr", 1'b1, S_NONE, V_RS1IMM);
    cyc("jalr.jal", 1'b1, S_JAL, V_JAL);
    cyc("jalr.wb", 1'b1, S_WB, V_ZERO);

    // sub x2,x1,x2 with one fetch wait
    set_ir(32'h40208133);
    cyc("sub.fetch_w", 1'b0, S_FET_W, V_FETCH);
    cyc("sub.fetch", 1'b1, S_FET_OK, V_FETCH);
    cyc("sub.dec", 1'b1, S_NONE, V_DEC);
    cyc("sub.exec", 1'b1, S_NONE, V_R_SUB);
    cyc("sub.wb", 1'b1, S_WB, V_ZERO);

    // srai x1,x1,3 -> SRA; addi with bit30 set stays ADD
    set_ir(32'h4030D093);
    cyc("srai.fetch", 1'b1, S_FET_OK, V_FETCH);
    cyc("srai.dec", 1'b1, S_NONE, V_DEC);
    cyc("srai.exec", 1'b1, S_NONE, V_I_SRA);
    cyc("srai.wb", 1'b1, S_WB, V_ZERO);
    set_ir(32'h40008093);
    cyc("addi.fetch", 1'b1, S_FET_OK, V_FETCH);
    cyc("addi.dec", 1'b1, S_NONE, V_DEC);
    cyc("addi.exec", 1'b1, S_NONE, V_RS1IMM);
    cyc("addi.wb", 1'b1, S_WB, V_ZERO);

    // lui x1,0x12345
    set_ir(32'h123450B7);
    cyc("lui.fetch", 1'b1, S_FET_OK, V_FETCH);
    check("lui.imm", {29'b0, imm_src}, 32'd3);
    cyc("lui.dec", 1'b1, S_NONE, V_DEC);
    cyc("lui.exec", 1'b1, S_NONE, V_LUI);
    cyc("lui.wb", 1'b1, S_WB, V_ZERO);

    // sw x2,4(x1) with one wait in MEM_WRITE
    set_ir(32'h0020A223);
    cyc("sw.fetch", 1'b1, S_FET_OK, V_FETCH);
    check("sw.imm", {29'b0, imm_src}, 32'd1);
    cyc("sw.dec", 1'b1, S_NONE, V_DEC);
    cyc("sw.addr", 1'b1, S_NONE, V_RS1IMM);
    cyc("sw.wr_w", 1'b0, S_WR_W, V_ZERO);
    cyc("sw.wr_ok", 1'b1, S_WR_OK, V_ZERO);

    // unknown opcode
    set_ir(32'h0000007F);
    cyc("ill.fetch", 1'b1, S_FET_OK, V_FETCH);
    cyc("ill.dec", 1'b1, S_ILL, V_DEC);
    cyc("ill.next", 1'b0, S_FET_W, V_FETCH);

    // sw aborted by reset while waiting in MEM_WRITE
    set_ir(32'h0020A223);
    cyc("swr.fetch", 1'b1, S_FET_OK, V_FETCH);
    cyc("swr.dec", 1'b1, S_NONE, V_DEC);
    cyc("swr.addr", 1'b0, S_NONE, V_RS1IMM);
    cyc("swr.wr_w", 1'b0, S_WR_W, V_ZERO);
    reset = 1'b1;
    cyc("swr.rst", 1'b0, S_NONE, V_ZERO);
    reset = 1'b0;
    cyc("swr.after", 1'b0, S_FET_W, V_FETCH);

    // ecall halts until reset
    set_ir(32'h00000073);
    cyc("ecall.fetch", 1'b1, S_FET_OK, V_FETCH);
    cyc("ecall.dec", 1'b1, S_NONE, V_DEC);
    for (int i = 0; i < 20; i++) cyc("halt", 1'b1, S_HALT, V_ZERO);
    reset = 1'b1;
    cyc("halt.rst", 1'b1, S_NONE, V_ZERO);
    reset = 1'b0;
    cyc("halt.after", 1'b1, S_FET_OK, V_FETCH);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Moore-style FSM that sequences the shared-resource RV32I multicycle datapath (single ALU, unified instruction/data memory, IR/old_pc/alu_out/data registers).
- Decodes the IR fields and issues per-cycle mux selects, write enables and ALU operation codes.
- Sits beside the datapath as the multicycle successor to the monocycle core.
- Handles variable-latency memory through a req/ready handshake.
- Supports R, I-ALU, lw, sw, branches, jal, jalr, lui, auipc and ecall/ebreak (halt).

Parameters:
- RESET_STATE_FETCH, 1, reset enters FETCH (1) or HALT (0, for bring-up debug).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7_5  in  1  IR[30]
- alu_zero  in  1  ALU result == 0
- alu_lt  in  1  signed rs1 < rs2 (from subtract)
- alu_ltu  in  1  unsigned rs1 < rs2
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  store strobe; valid only with mem_req
- adr_src  out  1  0 = PC, 1 = alu_out
- ir_write  out  1  latch IR and old_pc
- pc_write  out  1  PC <= result
- reg_write  out  1  register-file write
- alu_src_a  out  2  00 PC, 01 old_pc, 10 rs1, 11 zero
- alu_src_b  out  2  00 rs2, 01 imm, 10 const 4
- result_src  out  2  00 alu_out, 01 mem data reg, 10 ALU result
- imm_src  out  3  000 I, 001 S, 010 B, 011 U, 100 J (opcode-decoded)
- alu_ctrl  out  4  ALU operation code (package enum)
- instr_retired  out  1  one-cycle pulse in each instruction's final state
- illegal_instr  out  1  one-cycle pulse in DECODE on an unknown opcode
- halted  out  1  high while in HALT

Behaviour:
- Reset: synchronous; state <= FETCH (or HALT per parameter). While reset is high, every strobe (mem_req, mem_write, ir_write, pc_write, reg_write, instr_retired, illegal_instr) is forced to 0. Selects go to 0 and halted goes to 0. Reset asserted mid-instruction aborts it with no write.
- States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, EXEC_U, ALU_WB, JALR_ADDR, JAL, BRANCH, HALT.
- FETCH:
  - Drives mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_ctrl=ADD, result_src=10.
  - ir_write and pc_write assert only in the cycle mem_ready=1, then the FSM moves to DECODE. Otherwise it holds with both low.
- DECODE:
  - Drives alu_src_a=01, alu_src_b=01, ADD; alu_out <= old_pc+imm.
  - Next state by opcode: 0000011/0100011 -> MEM_ADDR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 0110111/0010111 -> EXEC_U; 1101111 -> JAL; 1100111 -> JALR_ADDR; 1100011 -> BRANCH; 1110011 -> HALT.
  - Any other opcode pulses illegal_instr and returns to FETCH.
- MEM_ADDR: drives rs1+imm; goes to MEM_READ for a load, MEM_WRITE for a store.
- MEM_READ: drives mem_req, adr_src=1; waits for mem_ready, then goes to MEM_WB.
- MEM_WB: drives result_src=01, reg_write, retire; then FETCH.
- MEM_WRITE: drives mem_req, mem_write, adr_src=1; on mem_ready, retires and goes to FETCH. mem_write must never assert without mem_req.
- EXEC_R: drives alu_src_a=10, alu_src_b=00.
  - alu_ctrl from funct3 and funct7_5: SUB for funct3=000 with funct7_5=1; SRA for funct3=101 with funct7_5=1.
  - Then ALU_WB.
- EXEC_I: same as EXEC_R with alu_src_b=01. funct7_5 selects SRA only when funct3=101; addi ignores funct7_5. Then ALU_WB.
- EXEC_U: alu_src_a=11 (lui) or 01 (auipc), alu_src_b=01, ADD; then ALU_WB.
- ALU_WB: result_src=00, reg_write, retire; then FETCH.
- JALR_ADDR: rs1+imm -> alu_out; then JAL.
- JAL: alu_src_a=01, alu_src_b=10, ADD; pc_write with result_src=00 (target); then ALU_WB writes old_pc+4.
- BRANCH:
  - Drives alu_src_a=10, alu_src_b=00, SUB.
  - taken = beq: zero; bne: !zero; blt: lt; bge: !lt; bltu: ltu; bgeu: !ltu. funct3 010/011 are never taken.
  - pc_write=taken with result_src=00; retire; then FETCH.
- HALT: all strobes low, halted=1; exits only on reset.
- Latency with zero wait states: branch 3; R/I/U/sw/jal 4; lw/jalr 5. Each wait cycle on mem_ready adds one cycle in FETCH, MEM_READ or MEM_WRITE.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state_t enum
  - alu_ctrl_t enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND)
  - opcode localparams
  - imm_src, alu_src_a/b and result_src encodings
- One sub-module, alu_decoder: combinational (state class, funct3, funct7_5, opcode) -> alu_ctrl. The FSM stays in the top module.

Test Plan:
- add x3,x1,x2 (0x002081B3), mem_ready tied 1 -> states FETCH, DECODE, EXEC_R, ALU_WB; reg_write=1 only in cycle 4; alu_ctrl=ADD; instr_retired pulses once.
- lw x5,8(x1) (0x0080A283) with mem_ready low 2 cycles in MEM_READ -> 7 cycles total; mem_req held high through waits; adr_src=1; reg_write with result_src=01 in the final cycle.
- beq (0x00208463): zero=1 -> pc_write=1 in BRANCH, 3-cycle retire. Same instruction with zero=0 -> pc_write stays 0.
- jalr x1,0(x2) (0x000100E7) -> 5 cycles; pc_write in JAL with result_src=00; reg_write in ALU_WB.
- Opcode 0x7F -> illegal_instr pulse in DECODE, then FETCH. ecall (0x00000073) -> halted=1, no strobes for 20 cycles until reset.
- Reset asserted in MEM_WRITE while mem_ready=0 -> mem_write/mem_req drop in that cycle; state is FETCH after release; no retire pulse.
